// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external combinational FP adder between two requesters.
// Optional FP_ADD_STICKY_FLAGS_EN adds sticky_clr/sticky_flags accumulation of adder flags.
module fp_add_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic [31:0] fpa_a,
  output logic [31:0] fpa_b,
  input  logic [31:0] fpa_result,
  input  logic [3:0]  fpa_flags,
  output logic        busy
`ifdef FP_ADD_STICKY_FLAGS_EN
  ,
  input  logic        sticky_clr,
  output logic [3:0]  sticky_flags
`endif
);

  if (EXEC_CYCLES < 1) begin : g_bad_cfg
    $error("fp_add_arbiter: EXEC_CYCLES must be >= 1");
  end

  localparam int CW = (EXEC_CYCLES < 1) ? 1 : $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]    flags_q, flags_d;
  logic          any_vld, grant;

  // Contention goes to rr_ptr; a lone requester wins regardless of the pointer.
  assign any_vld = req0_valid | req1_valid;
  assign grant   = (req0_valid & req1_valid) ? rr_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    flags_d    = flags_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: if (any_vld) begin
        req0_ready = ~grant;
        req1_ready = grant;
        a_d        = grant ? req1_a : req0_a;
        b_d        = grant ? req1_b : req0_b;
        owner_d    = grant;
        rr_d       = ~grant;
        cnt_d      = '0;
        state_d    = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          data_d  = fpa_result;
          flags_d = fpa_flags;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

`ifdef FP_ADD_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // Clear beats a same-cycle capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   sticky_q <= '0;
    else if (sticky_clr)                         sticky_q <= '0;
    else if (state_q == EXEC && cnt_q == CNT_LAST) sticky_q <= sticky_q | fpa_flags;
  end

  assign sticky_flags = sticky_q;
`endif

  assign fpa_a     = a_q;
  assign fpa_b     = b_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: one instance at EXEC_CYCLES=1, one at EXEC_CYCLES=4.
module tb_fp_add_arbiter;
  logic clk, reset, r4;
  logic req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_data, fpa_a, fpa_b, fpa_result;
  logic [3:0]  rsp_flags, fpa_flags;
  logic r4_req0_ready, r4_req1_ready, r4_rsp0_valid, r4_rsp1_valid, r4_busy;
  logic [31:0] r4_rsp_data, r4_fpa_a, r4_fpa_b, r4_fpa_result;
  logic [3:0]  r4_rsp_flags, r4_fpa_flags;
`ifdef FP_ADD_STICKY_FLAGS_EN
  logic sticky_clr;
  logic [3:0] sticky_flags, r4_sticky_flags;
`endif
  int total = 0;
  int bad = 0;

  // Stand-in adder: known IEEE vectors, otherwise an integer sum with clear flags.
  function automatic logic [35:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return {4'b0010, 32'h40000000};
    if (a == 32'h40200000 && b == 32'hC0200000) return {4'b0100, 32'h00000000};
    return {4'b0000, a + b};
  endfunction

  assign {fpa_flags, fpa_result}       = fadd(fpa_a, fpa_b);
  assign {r4_fpa_flags, r4_fpa_result} = fadd(r4_fpa_a, r4_fpa_b);

  fp_add_arbiter #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_result(fpa_result), .fpa_flags(fpa_flags),
    .busy(busy)
`ifdef FP_ADD_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
`endif
  );

  fp_add_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(r4),
    .req0_valid(req0_valid), .req0_ready(r4_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r4_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(r4_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(r4_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(r4_rsp_data), .rsp_flags(r4_rsp_flags),
    .fpa_a(r4_fpa_a), .fpa_b(r4_fpa_b), .fpa_result(r4_fpa_result), .fpa_flags(r4_fpa_flags),
    .busy(r4_busy)
`ifdef FP_ADD_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(r4_sticky_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input bit who, input logic [31:0] a, input logic [31:0] b);
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; r4 = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
`ifdef FP_ADD_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_v0", rsp0_valid, 0);
    chk("rst_v1", rsp1_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_fpa_a", fpa_a, 0);
    chk("rst_fpa_b", fpa_b, 0);
    reset = 1'b0;
    tick();
    chk("idle_rdy0", req0_ready, 0);

    // 1.0 + 1.0 from requester 0
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    #1 chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_v0", rsp0_valid, 0);
    chk("t1_exec_rdy0", req0_ready, 0);
    chk("t1_fpa_a", fpa_a, 32'h3F800000);
    tick();
    chk("t1_v0", rsp0_valid, 1);
    chk("t1_v1", rsp1_valid, 0);
    chk("t1_data", rsp_data, 32'h40000000);
    chk("t1_flags", rsp_flags, 4'b0010);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_v0", rsp0_valid, 0);
    chk("t1_hold_fpa_a", fpa_a, 32'h3F800000);

    // 2.5 + -2.5 from requester 1
    req1_valid = 1; req1_a = 32'h40200000; req1_b = 32'hC0200000;
    #1 chk("t2_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("t2_v1", rsp1_valid, 1);
    chk("t2_v0", rsp0_valid, 0);
    chk("t2_data", rsp_data, 32'h0);
    chk("t2_flags", rsp_flags, 4'b0100);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // both valid from reset: strict alternation starting at 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1; req0_a = 32'h1;  req0_b = 32'h2;
    req1_valid = 1; req1_a = 32'h10; req1_b = 32'h20;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("alt_rdy0", req0_ready, (k % 2 == 0));
      chk("alt_rdy1", req1_ready, (k % 2 == 1));
      tick();
      tick();
      chk("alt_v0", rsp0_valid, (k % 2 == 0));
      chk("alt_v1", rsp1_valid, (k % 2 == 1));
      chk("alt_data", rsp_data, (k % 2 == 1) ? 32'h30 : 32'h3);
      tick();
    end
    // lone requester served back-to-back
    req1_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("lone_rdy0", req0_ready, 1);
      tick();
      tick();
      chk("lone_v0", rsp0_valid, 1);
      tick();
    end
    req0_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // response stall with another request pending
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    #1 chk("st_rdy0", req0_ready, 1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'h40200000; req1_b = 32'hC0200000;
    #1 chk("st_exec_rdy1", req1_ready, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("st_v0", rsp0_valid, 1);
      chk("st_v1", rsp1_valid, 0);
      chk("st_data", rsp_data, 32'h40000000);
      chk("st_flags", rsp_flags, 4'b0010);
      chk("st_rdy0", req0_ready, 0);
      chk("st_rdy1", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1;
    #1 chk("st_hs_v0", rsp0_valid, 1);
    tick();
    rsp0_ready = 0;
    #1 chk("st_resume_rdy1", req1_ready, 1);
    chk("st_resume_busy", busy, 0);
    tick();
    req1_valid = 0;
    tick();
    chk("st_r1_v1", rsp1_valid, 1);
    chk("st_r1_data", rsp_data, 32'h0);
    chk("st_r1_flags", rsp_flags, 4'b0100);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

`ifdef FP_ADD_STICKY_FLAGS_EN
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    chk("sticky_clr0", sticky_flags, 0);
    run_op(1'b1, 32'h40200000, 32'hC0200000);
    chk("sticky_zero", sticky_flags, 4'b0100);
    run_op(1'b0, 32'h3F800000, 32'h3F800000);
    chk("sticky_acc", sticky_flags, 4'b0110);
    req0_valid = 1;
    tick();
    req0_valid = 0;
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    chk("sticky_clr_wins", sticky_flags, 0);
    chk("sticky_clr_rsp", rsp_flags, 4'b0010);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
`endif

    // EXEC_CYCLES=4: async reset mid-EXEC, then full-latency replay
    r4 = 1'b0;
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    #1 chk("r4_rdy0", r4_req0_ready, 1);
    tick();
    chk("r4_exec_busy", r4_busy, 1);
    tick();
    #2 r4 = 1'b1;
    #1 chk("r4_async_busy", r4_busy, 0);
    chk("r4_async_fpa_a", r4_fpa_a, 0);
    chk("r4_async_v0", r4_rsp0_valid, 0);
    chk("r4_async_data", r4_rsp_data, 0);
    chk("r4_async_flags", r4_rsp_flags, 0);
    @(negedge clk);
    r4 = 1'b0;
    #1 chk("r4_re_rdy0", r4_req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("r4_t1_v0", r4_rsp0_valid, 0);
    repeat (3) tick();
    chk("r4_t4_v0", r4_rsp0_valid, 0);
    tick();
    chk("r4_t5_v0", r4_rsp0_valid, 1);
    chk("r4_t5_v1", r4_rsp1_valid, 0);
    chk("r4_data", r4_rsp_data, 32'h40000000);
    chk("r4_flags", r4_rsp_flags, 4'b0010);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    chk("r4_done_busy", r4_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
